// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS (grant) -> RESP (completion) over one synchronous memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with port 0 winning ties.
module mem_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    input  logic        halt_m0,
    output logic [31:0] address,
    output logic [31:0] data_out,
    output logic        we,
    input  logic [31:0] data_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t     state, state_nxt;
    req_t [1:0] req;
    logic [1:0] elig;
    logic       sample;
    logic       grant_now;
    logic       win;
    logic       owner;

    assign req[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign req[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

    // Port 0 is masked out entirely while halted; an access already sampled is unaffected.
    assign elig      = {m1_req, m0_req & ~halt_m0};
    assign sample    = (state == IDLE) || (state == RESP);
    assign grant_now = sample && (elig != 2'b00);

`ifdef MEM_ARB_RR_EN
    logic ptr;

    // A lone request wins outright; on a tie the pointer names the port not granted last.
    always_comb begin
        win = elig[1];
        if (elig == 2'b11)
            win = ptr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ptr <= 1'b0;
        else if (grant_now)
            ptr <= ~win;
    end
`else
    always_comb begin
        win = ~elig[0];
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_now ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = grant_now ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // we is registered high only for the cycle that follows a sample, so it is high exactly in ACCESS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner    <= 1'b0;
            address  <= '0;
            data_out <= '0;
            we       <= 1'b0;
        end else if (grant_now) begin
            owner    <= win;
            address  <= req[win].addr;
            data_out <= req[win].wdata;
            we       <= req[win].we;
        end else begin
            we       <= 1'b0;
        end
    end

    assign m0_gnt    = (state == ACCESS) && !owner;
    assign m1_gnt    = (state == ACCESS) &&  owner;
    assign m0_rvalid = (state == RESP)   && !owner;
    assign m1_rvalid = (state == RESP)   &&  owner;
    assign m0_rdata  = m0_rvalid ? data_in : '0;
    assign m1_rdata  = m1_rvalid ? data_in : '0;

    a_one_gnt: assert property (@(posedge clk) disable iff (!resetn) !(m0_gnt && m1_gnt));
    a_one_rv:  assert property (@(posedge clk) disable iff (!resetn) !(m0_rvalid && m1_rvalid));
    a_we_acc:  assert property (@(posedge clk) disable iff (!resetn) we |-> (state == ACCESS));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports m0_req/m1_req, input, 1 bit each: access request. Port 0 is the core; port 1 is the loader/debug.
REQ-004 SHALL have ports m0_we/m1_we, input, 1 bit each: write enable; ports m0_addr/m1_addr, input, 32 bits each: byte address; ports m0_wdata/m1_wdata, input, 32 bits each: write data.
REQ-005 SHALL have ports m0_gnt/m1_gnt, output, 1 bit each: one-cycle grant pulse.
REQ-006 SHALL have ports m0_rvalid/m1_rvalid, output, 1 bit each: one-cycle completion pulse; ports m0_rdata/m1_rdata, output, 32 bits each: read data.
REQ-007 SHALL have port halt_m0, input, 1 bit: when high, no new grants are issued to port 0.
REQ-008 SHALL have ports address, output, 32 bits; data_out, output, 32 bits; we, output, 1 bit; data_in, input, 32 bits. These form the single memory port. Memory writes on the clk edge when we=1. Read data appears on data_in one cycle after address.

Function
REQ-009 SHALL implement the states IDLE, ACCESS and RESP.
REQ-010 SHALL sample requests in IDLE and RESP. If any eligible request is present, at the edge it SHALL register the winner's addr, we and wdata onto address, we and data_out, and go to ACCESS. Otherwise it SHALL go to or stay in IDLE.
REQ-011 SHALL, in ACCESS, assert mN_gnt for the winner for exactly one cycle, with address, we and data_out stable; the next state is always RESP.
REQ-012 SHALL, in RESP, force we=0, assert mN_rvalid for the winner for one cycle, and drive mN_rdata=data_in for that cycle. rvalid SHALL also pulse for writes, as a write acknowledge; rdata is don't-care in that case.
REQ-013 SHALL give a latency of 2 cycles from request-sampled edge to rvalid. Back-to-back throughput is 1 access per 2 cycles (RESP to ACCESS directly).
REQ-014 SHALL require the requester to hold req, addr, we and wdata stable until gnt, and to drop req in the cycle after gnt unless it has a new request.
REQ-015 SHALL drive at most one gnt and at most one rvalid in any cycle. mN_rdata SHALL be 0 whenever mN_rvalid=0.
REQ-016 SHALL exclude port 0 from arbitration while halt_m0=1. An access already past sampling SHALL complete normally.
REQ-017 SHALL hold address and data_out at their last values outside ACCESS; we SHALL be 1 only in ACCESS.
REQ-018 SHALL resolve simultaneous requests per REQ-022. A single eligible request always wins.

Reset
REQ-019 SHALL, on resetn=0, immediately set state=IDLE, we=0, address=0, data_out=0, all gnt=0, all rvalid=0, all rdata=0, and the priority pointer to port 0.
REQ-020 SHALL, on reset assertion mid-access, abort the access: no rvalid issued and we drops asynchronously. The first sampling is at the first rising edge after resetn=1.

Configuration
REQ-021 SHALL use macro MEM_ARB_RR_EN.
REQ-022 SHALL arbitrate as follows. With MEM_ARB_RR_EN defined: round-robin; the pointer moves to the other port after each grant, so on a simultaneous request the port not granted last wins. Without MEM_ARB_RR_EN: fixed priority, port 0 always wins a tie and the pointer is unused.

Verification
REQ-023 SHALL cover a single read: memory word 0x100 = 0xDEADBEEF; m0 reads 0x100. Required: m0_gnt in cycle T+1, m0_rvalid with m0_rdata=0xDEADBEEF in cycle T+2, we=0 throughout.
REQ-024 SHALL cover a write then read: m1 writes 0x12345678 to 0x800, then m1 reads 0x800. Required: we=1 only in the write's ACCESS cycle, and the read returns 0x12345678.
REQ-025 SHALL cover contention: m0 and m1 request continuously for 4 grants. With MEM_ARB_RR_EN the grant order is m0,m1,m0,m1. Without it the order is m0,m0,m0,m0 and m1 starves.
REQ-026 SHALL cover halt: halt_m0=1 with both requesting. Only m1 is granted. On halt_m0=0, m0 is granted at the next sample.
REQ-027 SHALL cover reset mid-op: resetn=0 during ACCESS of a write. we drops in the same cycle, no rvalid follows, and all outputs are 0. After release, a pending m0 request is granted normally.
